// File: rtl/spi_ram_ctrl_pkg.sv
// Shared definitions for the SPI-to-RAM command path.
// Contents:
//   cmd_e   - 2-bit command field of a received frame (same encoding the SPI slave uses)
//   state_e - controller FSM states
//   frame_t - 10-bit received frame {cmd, payload}
package spi_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_RD_REQ = 2'd2,
    ST_RD_CAP = 2'd3
  } state_e;

  typedef struct packed {
    cmd_e       cmd;
    logic [7:0] payload;
  } frame_t;

endpackage

// File: rtl/spi_ram_array.sv
// 8-bit single-clock RAM: one write port, one read port with a registered
// output (data appears the cycle after re). Contents are never reset.
// Ports:
//   clk           system clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr           read request
//   o_rdata                read data, valid the cycle after i_re
module spi_ram_array #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command controller between the SPI slave and an on-chip RAM.
// Decodes 10-bit frames {cmd, payload} into address/data operations, sequences
// the RAM and hands read data back to the slave for its next frame.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   rx_data       received frame, [9:8]=cmd, [7:0]=payload
//   rx_valid      1-cycle strobe for rx_data
//   tx_data       read data for the slave
//   tx_valid      tx_data valid; held until the next accepted command
//   busy          FSM not in IDLE
//   err           1-cycle pulse on a rejected command
module spi_ram_ctrl
  import spi_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AUTO_INC = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       err
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_ok;
  logic              r_rd_ok;
  logic [7:0]        r_wdata;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_busy;
  logic              r_err;

  frame_t            w_frame;
  logic [ADDR_W-1:0] w_pl_addr;
  logic              w_in_range;
  logic              w_we;
  logic              w_re;
  logic [7:0]        w_rdata;

  assign w_frame    = frame_t'(rx_data);
  assign w_pl_addr  = w_frame.payload[ADDR_W-1:0];
  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  assign w_in_range = ({1'b0, w_pl_addr} < (ADDR_W+1)'(DEPTH));
  assign w_we       = (r_state == ST_WRITE);
  assign w_re       = (r_state == ST_RD_REQ);

  function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_wr_ok    <= 1'b0;
      r_rd_ok    <= 1'b0;
      r_wdata    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // A rejected command leaves everything (including tx_valid) alone.
          if (rx_valid) begin
            unique case (w_frame.cmd)
              CMD_WR_ADDR: begin
                if (w_in_range) begin
                  r_wr_addr  <= w_pl_addr;
                  r_wr_ok    <= 1'b1;
                  r_tx_valid <= 1'b0;
                end else r_err <= 1'b1;
              end
              CMD_WR_DATA: begin
                if (r_wr_ok) begin
                  r_wdata    <= w_frame.payload;
                  r_state    <= ST_WRITE;
                  r_busy     <= 1'b1;
                  r_tx_valid <= 1'b0;
                end else r_err <= 1'b1;
              end
              CMD_RD_ADDR: begin
                if (w_in_range) begin
                  r_rd_addr  <= w_pl_addr;
                  r_rd_ok    <= 1'b1;
                  r_tx_valid <= 1'b0;
                end else r_err <= 1'b1;
              end
              CMD_RD_DATA: begin
                if (r_rd_ok) begin
                  r_state    <= ST_RD_REQ;
                  r_busy     <= 1'b1;
                  r_tx_valid <= 1'b0;
                end else r_err <= 1'b1;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (AUTO_INC != 0) r_wr_addr <= f_inc(r_wr_addr);
        end
        ST_RD_REQ: begin
          r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_tx_data  <= w_rdata;
          r_tx_valid <= 1'b1;
          if (AUTO_INC != 0) r_rd_addr <= f_inc(r_rd_addr);
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // Frames arriving mid-operation are dropped and flagged.
      if (rx_valid && (r_state != ST_IDLE)) r_err <= 1'b1;
    end
  end

  spi_ram_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (r_wdata),
    .i_re    (w_re),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rdata)
  );

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl. Two instances share clock and reset:
//   dut0: DEPTH=256, AUTO_INC=0    dut1: DEPTH=16, AUTO_INC=1
// A transaction-level model tracks RAM contents, address registers and the
// busy/tx timeline; outputs are compared against it on every falling edge.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rxd  [2];
  logic       rxv  [2];
  logic [7:0] txd  [2];
  logic       txv  [2];
  logic       bsy  [2];
  logic       err  [2];

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_W(8), .DEPTH(256), .AUTO_INC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rxd[0]), .rx_valid(rxv[0]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .busy(bsy[0]), .err(err[0]));

  spi_ram_ctrl #(.ADDR_W(8), .DEPTH(16), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rxd[1]), .rx_valid(rxv[1]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .busy(bsy[1]), .err(err[1]));

  int dep [2] = '{256, 16};
  int ai  [2] = '{0, 1};

  // ---------------- reference model ----------------
  logic [7:0] mem   [2][256];
  bit         memk  [2][256];
  int         m_wa  [2];
  int         m_ra  [2];
  int         m_busy[2];   // remaining busy cycles
  bit         m_wok [2];
  bit         m_rok [2];
  bit         m_txv [2];
  bit         m_err [2];
  bit         m_txk [2];   // tx data known
  bit         m_rdp [2];   // read in flight
  bit         m_pk  [2];
  logic [7:0] m_txd [2];
  logic [7:0] m_pd  [2];
  bit         live = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int cmd;
      int a;
      bit e;
      bit bz;
      if (!rst_n) begin
        live      = 1'b1;
        m_wa[d]   = 0;  m_ra[d]  = 0;
        m_wok[d]  = 0;  m_rok[d] = 0;
        m_busy[d] = 0;  m_rdp[d] = 0;
        m_txv[d]  = 0;  m_err[d] = 0;
        m_txd[d]  = 8'h00;
        m_txk[d]  = 1;
      end else begin
        e  = 0;
        bz = (m_busy[d] > 0);
        if (m_busy[d] > 0) begin
          m_busy[d]--;
          if (m_busy[d] == 0 && m_rdp[d]) begin
            m_txv[d] = 1;  m_txd[d] = m_pd[d];  m_txk[d] = m_pk[d];  m_rdp[d] = 0;
          end
        end
        if (rxv[d]) begin
          cmd = int'(rxd[d][9:8]);
          a   = int'(rxd[d][7:0]);
          if (bz) e = 1;
          else case (cmd)
            0: if (a >= dep[d]) e = 1;
               else begin m_wa[d] = a; m_wok[d] = 1; m_txv[d] = 0; end
            1: if (!m_wok[d]) e = 1;
               else begin
                 mem[d][m_wa[d]]  = rxd[d][7:0];
                 memk[d][m_wa[d]] = 1;
                 m_txv[d]  = 0;
                 m_busy[d] = 1;
                 if (ai[d] != 0) m_wa[d] = (m_wa[d] + 1) % dep[d];
               end
            2: if (a >= dep[d]) e = 1;
               else begin m_ra[d] = a; m_rok[d] = 1; m_txv[d] = 0; end
            default: if (!m_rok[d]) e = 1;
               else begin
                 m_pd[d]   = mem[d][m_ra[d]];
                 m_pk[d]   = memk[d][m_ra[d]];
                 m_rdp[d]  = 1;
                 m_txv[d]  = 0;
                 m_busy[d] = 2;
                 if (ai[d] != 0) m_ra[d] = (m_ra[d] + 1) % dep[d];
               end
          endcase
        end
        m_err[d] = e;
      end
    end
  end

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
  endtask

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (live) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, int'(bsy[d]), int'(m_busy[d] > 0));
        chk("err", d, int'(err[d]), int'(m_err[d]));
        chk("tx_valid", d, int'(txv[d]), int'(m_txv[d]));
        if (m_txk[d]) chk("tx_data", d, int'(txd[d]), int'(m_txd[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  // All tasks start and end on a falling edge.
  task automatic send(input int d, input logic [1:0] c, input logic [7:0] p);
    rxd[d] = {c, p};
    rxv[d] = 1'b1;
    @(negedge clk);
    rxv[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input int d, input logic [1:0] c, input logic [7:0] p);
    send(d, c, p);
    idle(4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] x;
    rst_n = 1'b0;
    rxv[0] = 1'b0;  rxv[1] = 1'b0;
    rxd[0] = '0;    rxd[1] = '0;
    @(negedge clk);
    do_reset();
    chk("rst_busy", 0, int'(bsy[0]), 0);
    chk("rst_txv", 1, int'(txv[1]), 0);

    // Reset in the middle of a read abandons it.
    cmd(0, 2'd0, 8'h00);
    cmd(0, 2'd1, 8'h77);
    cmd(0, 2'd2, 8'h00);
    send(0, 2'd3, 8'h00);
    do_reset();
    chk("midrd_txv", 0, int'(txv[0]), 0);
    chk("midrd_busy", 0, int'(bsy[0]), 0);
    chk("midrd_err", 0, int'(err[0]), 0);
    idle(10);
    send(0, 2'd3, 8'h00);
    chk("rd_noaddr_err", 0, int'(err[0]), 1);
    chk("rd_noaddr_busy", 0, int'(bsy[0]), 0);
    idle(4);

    // Write with no address is rejected; RAM keeps pre-reset contents.
    send(0, 2'd1, 8'h11);
    chk("wr_noaddr_err", 0, int'(err[0]), 1);
    idle(3);
    cmd(0, 2'd2, 8'h00);
    send(0, 2'd3, 8'h00);
    idle(2);
    chk("ram0_kept", 0, int'(txd[0]), 'h77);
    idle(2);

    // Basic write/read with exact latency.
    cmd(0, 2'd0, 8'h05);
    cmd(0, 2'd1, 8'hA5);
    cmd(0, 2'd2, 8'h05);
    send(0, 2'd3, 8'h00);
    chk("rd_clr_txv", 0, int'(txv[0]), 0);
    idle(1);
    chk("rd_n2_txv", 0, int'(txv[0]), 0);
    idle(1);
    chk("rd_n3_txv", 0, int'(txv[0]), 1);
    chk("rd_n3_data", 0, int'(txd[0]), 'hA5);

    // tx_valid holds until the next accepted frame.
    idle(50);
    chk("hold_txv", 0, int'(txv[0]), 1);
    send(0, 2'd2, 8'h00);
    chk("consume_txv", 0, int'(txv[0]), 0);
    idle(4);

    // Frame during RD_REQ is dropped and does not clear tx_valid.
    cmd(0, 2'd2, 8'h05);
    send(0, 2'd3, 8'h00);
    send(0, 2'd0, 8'h09);
    chk("busy_drop_err", 0, int'(err[0]), 1);
    idle(1);
    chk("busy_drop_txv", 0, int'(txv[0]), 1);
    chk("busy_drop_data", 0, int'(txd[0]), 'hA5);
    idle(3);
    cmd(0, 2'd1, 8'h5B);
    send(0, 2'd3, 8'h00);
    idle(2);
    chk("wa_unchanged", 0, int'(txd[0]), 'h5B);
    idle(2);

    // DEPTH=16: out-of-range address rejected, register unchanged.
    cmd(1, 2'd0, 8'h05);
    send(1, 2'd0, 8'h20);
    chk("oor_err", 1, int'(err[1]), 1);
    idle(4);
    cmd(1, 2'd1, 8'h33);
    cmd(1, 2'd2, 8'h05);
    send(1, 2'd3, 8'h00);
    idle(2);
    chk("oor_wa_kept", 1, int'(txd[1]), 'h33);
    idle(2);

    // AUTO_INC wrap 15 -> 0.
    cmd(1, 2'd0, 8'h0F);
    cmd(1, 2'd1, 8'h11);
    cmd(1, 2'd1, 8'h22);
    chk("model_mem15", 1, int'(mem[1][15]), 'h11);
    chk("model_mem0", 1, int'(mem[1][0]), 'h22);
    cmd(1, 2'd2, 8'h0F);
    send(1, 2'd3, 8'h00);
    idle(2);
    chk("inc_rd1", 1, int'(txd[1]), 'h11);
    idle(2);
    send(1, 2'd3, 8'h00);
    idle(2);
    chk("inc_rd2", 1, int'(txd[1]), 'h22);
    chk("inc_rd2_txv", 1, int'(txv[1]), 1);
    idle(2);

    // Random write/read pairs, one frame every 12 clocks.
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      x = 8'($urandom);
      send(0, 2'd0, a);  idle(11);
      send(0, 2'd1, x);  idle(11);
      send(0, 2'd2, a);  idle(11);
      send(0, 2'd3, $urandom);
      idle(2);
      chk("rand_rd", 0, int'(txd[0]), int'(x));
      idle(9);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
